control_unit: RTL

//  Hardwired control sequencer that drives the datapath control inputs in place of bench-driven T-steps.
//  It runs fetch (T0-T2), decodes IR[31:27], and executes one control step per Clock.
//  It drives every datapath strobe, the GRA/GRB/GRC/Rin/Rout/BAout select group, CON_in and the 5-bit ALU operation.

---
 rtl/control_unit_pkg.sv | 100 ++++++++++
 rtl/control_unit_opcode_classifier.sv | 36 +++
 rtl/control_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared definitions for the hardwired control sequencer and the datapath
//   ALU: instruction opcodes (IR[31:27]), ALU operation codes, sequencer
//   state encoding, instruction classes and small decode helpers.
package control_unit_pkg;

  // Instruction opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes share the arithmetic opcode values
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_NOP = 5'b00000;

  // Sequencer states; T3..T7 must stay contiguous and ascending because the
  // execute phase advances by +1 and ends on a >= comparison.
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  // Instruction classes: every opcode sharing a step sequence maps to one class
  typedef enum logic [3:0] {
    CLS_RTYPE  = 4'd0,
    CLS_IMM    = 4'd1,
    CLS_MULDIV = 4'd2,
    CLS_UNARY  = 4'd3,
    CLS_LDI    = 4'd4,
    CLS_LD     = 4'd5,
    CLS_ST     = 4'd6,
    CLS_BR     = 4'd7,
    CLS_JR     = 4'd8,
    CLS_JAL    = 4'd9,
    CLS_IN     = 4'd10,
    CLS_OUT    = 4'd11,
    CLS_MFHI   = 4'd12,
    CLS_MFLO   = 4'd13,
    CLS_NOP    = 4'd14,
    CLS_HALT   = 4'd15
  } iclass_e;

  // Final execute step of each class; classes without execute steps end at T2
  function automatic state_e last_step(input iclass_e cls);
    case (cls)
      CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: last_step = ST_T3;
      CLS_JAL, CLS_UNARY:                          last_step = ST_T4;
      CLS_RTYPE, CLS_IMM, CLS_LDI:                 last_step = ST_T5;
      CLS_MULDIV, CLS_BR:                          last_step = ST_T6;
      CLS_LD, CLS_ST:                              last_step = ST_T7;
      default:                                     last_step = ST_T2;
    endcase
  endfunction

  // ALU operation used by the immediate forms
  function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
    case (opcode)
      OP_ADDI: imm_alu_op = ALU_ADD;
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_opcode_classifier.sv
// opcode_classifier
//   Combinational map from the 5-bit opcode field to the instruction class
//   that selects the execute-step sequence. Unlisted opcodes are NOP.
//   Ports: opcode_i (5) opcode field IR[31:27]; iclass_o instruction class.
module opcode_classifier
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_e    iclass_o
);

  // Opcode to class lookup
  always_comb begin
    iclass_o = CLS_NOP;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:        iclass_o = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       iclass_o = CLS_IMM;
      OP_MUL, OP_DIV:                 iclass_o = CLS_MULDIV;
      OP_NEG, OP_NOT:                 iclass_o = CLS_UNARY;
      OP_LDI:                         iclass_o = CLS_LDI;
      OP_LD:                          iclass_o = CLS_LD;
      OP_ST:                          iclass_o = CLS_ST;
      OP_BR:                          iclass_o = CLS_BR;
      OP_JR:                          iclass_o = CLS_JR;
      OP_JAL:                         iclass_o = CLS_JAL;
      OP_IN:                          iclass_o = CLS_IN;
      OP_OUT:                         iclass_o = CLS_OUT;
      OP_MFHI:                        iclass_o = CLS_MFHI;
      OP_MFLO:                        iclass_o = CLS_MFLO;
      OP_HALT:                        iclass_o = CLS_HALT;
      default:                        iclass_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Hardwired control sequencer: fetch (T0-T2), decode of IR[31:27], then one
//   execute step per Clock. Outputs decode from the state register (plus the
//   instruction class); the only input that reaches an output directly is
//   CON_out, which drives PCin during the branch T6 step.
//   Ports:
//     Clock, Reset (sync, active-low), IR (instruction), CON_out (branch flag),
//     Stop (halt at next instruction boundary)
//     bus drivers:   PCout Zlowout ZHighout MDRout HIout LOout Cout InPortout
//     reg loads:     MARin Zin PCin MDRin IRin Yin HIin LOin OutPortin CON_in
//     strobes:       IncPC Read Write
//     select group:  GRA GRB GRC Rin Rout BAout R15sel
//     operation (ALU op), Run (1 while executing)
module control_unit
  import control_unit_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [IRW-1:0] IR,
  input  logic           CON_out,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           HIout,
  output logic           LOout,
  output logic           Cout,
  output logic           InPortout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           OutPortin,
  output logic           CON_in,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           GRA,
  output logic           GRB,
  output logic           GRC,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           R15sel,
  output logic [OPW-1:0] operation,
  output logic           Run
);

  state_e         state_q;
  state_e         state_d;
  iclass_e        cls_s;
  state_e         boundary_s;
  logic [OPW-1:0] opcode_s;
  logic           unused_ir_s;

  assign opcode_s    = IR[IRW-1 -: OPW];
  // Operand/immediate fields belong to the datapath, not the sequencer
  assign unused_ir_s = ^IR[IRW-OPW-1:0];

  opcode_classifier u_classifier (
    .opcode_i (opcode_s),
    .iclass_o (cls_s)
  );

  // Where an instruction boundary goes: HALT when Stop is requested
  assign boundary_s = Stop ? ST_HALT : ST_T0;

  // State register with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:  state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        if (cls_s == CLS_HALT) begin
          state_d = ST_HALT;
        end else if (cls_s == CLS_NOP) begin
          state_d = boundary_s;
        end else begin
          state_d = ST_T3;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: begin
        // Execute steps; >= also recovers if IR changes under an instruction
        if (state_q >= last_step(cls_s)) begin
          state_d = boundary_s;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
  end

  // Step-output decode
  always_comb begin
    PCout = 1'b0;  Zlowout = 1'b0;  ZHighout = 1'b0;  MDRout = 1'b0;
    HIout = 1'b0;  LOout = 1'b0;    Cout = 1'b0;      InPortout = 1'b0;
    MARin = 1'b0;  Zin = 1'b0;      PCin = 1'b0;      MDRin = 1'b0;
    IRin = 1'b0;   Yin = 1'b0;      HIin = 1'b0;      LOin = 1'b0;
    OutPortin = 1'b0;  CON_in = 1'b0;
    IncPC = 1'b0;  Read = 1'b0;     Write = 1'b0;
    GRA = 1'b0;    GRB = 1'b0;      GRC = 1'b0;       Rin = 1'b0;
    Rout = 1'b0;   BAout = 1'b0;    R15sel = 1'b0;
    operation = ALU_NOP;
    Run = (state_q != ST_RST) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls_s)
          CLS_RTYPE, CLS_IMM:        begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_MULDIV:                begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_UNARY: begin
            GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode_s;
          end
          CLS_LDI, CLS_LD, CLS_ST:   begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_BR:                    begin GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
          CLS_JR:                    begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          CLS_JAL:                   begin PCout = 1'b1; Rin = 1'b1; R15sel = 1'b1; end
          CLS_IN:                    begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_OUT:                   begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          CLS_MFHI:                  begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_MFLO:                  begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls_s)
          CLS_RTYPE: begin
            GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode_s;
          end
          CLS_IMM:    begin Cout = 1'b1; Zin = 1'b1; operation = imm_alu_op(opcode_s); end
          CLS_MULDIV: begin
            GRB = 1'b1; Rout = 1'b1; Zin = 1'b1; operation = opcode_s;
          end
          CLS_UNARY:                 begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_LDI, CLS_LD, CLS_ST:   begin Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD; end
          CLS_BR:                    begin PCout = 1'b1; Yin = 1'b1; end
          CLS_JAL:                   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls_s)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_MULDIV:                  begin Zlowout = 1'b1; LOin = 1'b1; end
          CLS_LD, CLS_ST:              begin Zlowout = 1'b1; MARin = 1'b1; end
          CLS_BR:                      begin Cout = 1'b1; Zin = 1'b1; operation = ALU_ADD; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls_s)
          CLS_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
          CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CLS_ST:     begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // Branch target is taken only when the registered condition holds
          CLS_BR:     begin Zlowout = 1'b1; PCin = CON_out; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls_s)
          CLS_LD:  begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
          CLS_ST:  begin Write = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
